// File: rtl/cochlea_pkg.sv
// Shared definitions for the cochlea readout path.
//   N_CH_DEFAULT / DEC_LOG2_DEFAULT : default channel count and log2 window length
//   state_e                         : readout FSM encoding (ST_IDLE = 0, ST_STREAM = 1)
//   popcount2                       : number of ones in a 2-bit cell read-out pair
package cochlea_pkg;

  localparam int N_CH_DEFAULT     = 8;
  localparam int DEC_LOG2_DEFAULT = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic logic [1:0] popcount2(input logic [1:0] b);
    return {1'b0, b[1]} + {1'b0, b[0]};
  endfunction

endpackage

// File: rtl/readout_ch_acc.sv
// Per-channel I/Q popcount accumulator with a shadow snapshot pair.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   sample_i                : add this cycle's pairs to the running sums
//   clear_i                 : window end; running sums restart from 0 next cycle
//   capture_i               : window end accepted; shadow takes the closing sums
//   ro_i_i, ro_q_i          : 2-bit I/Q read-out pair of this channel
//   shadow_i_o, shadow_q_o  : last captured window sums
module readout_ch_acc
  import cochlea_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sample_i,
  input  logic             clear_i,
  input  logic             capture_i,
  input  logic [1:0]       ro_i_i,
  input  logic [1:0]       ro_q_i,
  output logic [ACC_W-1:0] shadow_i_o,
  output logic [ACC_W-1:0] shadow_q_o
);

  logic [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [ACC_W-1:0] sh_i_q, sh_i_d, sh_q_q, sh_q_d;
  logic [ACC_W-1:0] sum_i, sum_q;
  logic [1:0]       pc_i, pc_q;

  always_comb begin
    pc_i = sample_i ? popcount2(ro_i_i) : 2'd0;
    pc_q = sample_i ? popcount2(ro_q_i) : 2'd0;
    // Closing sums include the window-end sample itself.
    sum_i = acc_i_q + {{(ACC_W-2){1'b0}}, pc_i};
    sum_q = acc_q_q + {{(ACC_W-2){1'b0}}, pc_q};
    acc_i_d = clear_i ? '0 : sum_i;
    acc_q_d = clear_i ? '0 : sum_q;
    sh_i_d  = capture_i ? sum_i : sh_i_q;
    sh_q_d  = capture_i ? sum_q : sh_q_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      sh_i_q  <= '0;
      sh_q_q  <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      sh_i_q  <= sh_i_d;
      sh_q_q  <= sh_q_d;
    end
  end

  assign shadow_i_o = sh_i_q;
  assign shadow_q_o = sh_q_q;

endmodule

// File: rtl/readout_decimator.sv
// Decimates the per-channel cochlea I/Q bitstreams by popcount over a window of
// 2**DEC_LOG2 sample strobes, snapshots all channels at window end and streams
// them out word by word (ch0 I, ch0 Q, ch1 I, ...) over valid/ready.
//   clk_master, rst          : clock, synchronous active-high reset
//   en, sample_en            : accumulate/count only when both are high
//   read_out_I, read_out_Q   : channel k on bits [2k+1:2k]
//   out_data/out_ch/out_q    : current word, its channel and I(0)/Q(1) flag
//   out_last, out_valid      : final word of frame, word available
//   out_ready                : consumer accepts on out_valid && out_ready
//   frame_cnt                : frames streamed (captured), wrapping 8-bit
//   overrun                  : sticky, a window ended while still streaming
//
// state     | meaning
// ST_IDLE   | waiting for a window end; shadow capture allowed
// ST_STREAM | presenting the captured frame; window ends here are dropped
module readout_decimator
  import cochlea_pkg::*;
#(
  parameter int N_CH     = N_CH_DEFAULT,
  parameter int DEC_LOG2 = DEC_LOG2_DEFAULT,
  parameter int ACC_W    = DEC_LOG2 + 2
) (
  input  logic                    clk_master,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sample_en,
  input  logic [2*N_CH-1:0]       read_out_I,
  input  logic [2*N_CH-1:0]       read_out_Q,
  output logic [ACC_W-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    out_q,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              frame_cnt,
  output logic                    overrun
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int IDX_W = CH_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*N_CH - 1);

  state_e              state_q, state_d;
  logic [DEC_LOG2-1:0] wcnt_q, wcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;

  logic fire, win_end, capture, streaming;
  logic [ACC_W-1:0] sh_i [N_CH];
  logic [ACC_W-1:0] sh_q [N_CH];
  logic [CH_W-1:0]  ch_sel;

  assign fire      = en && sample_en;
  assign win_end   = fire && (wcnt_q == '1);
  // Capture is decided on the registered state, so a window closing on the
  // same edge as the last-word acceptance is dropped rather than captured.
  assign capture   = win_end && (state_q == ST_IDLE);
  assign streaming = (state_q == ST_STREAM);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    readout_ch_acc #(.ACC_W(ACC_W)) u_acc (
      .clk_i      (clk_master),
      .rst_i      (rst),
      .sample_i   (fire),
      .clear_i    (win_end),
      .capture_i  (capture),
      .ro_i_i     (read_out_I[2*k+1:2*k]),
      .ro_q_i     (read_out_Q[2*k+1:2*k]),
      .shadow_i_o (sh_i[k]),
      .shadow_q_o (sh_q[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    wcnt_d      = fire ? wcnt_q + 1'b1 : wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d     = ST_STREAM;
          idx_d       = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_STREAM: begin
        if (win_end) overrun_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs come only from registers, so out_ready never reaches out_valid.
  assign ch_sel    = idx_q[IDX_W-1:1];
  assign out_valid = streaming;
  assign out_ch    = streaming ? ch_sel : '0;
  assign out_q     = streaming && idx_q[0];
  assign out_last  = streaming && (idx_q == LAST_IDX);
  assign out_data  = !streaming ? '0 : (idx_q[0] ? sh_q[ch_sel] : sh_i[ch_sel]);
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_readout_decimator.sv
module tb_readout_decimator;

  logic       clk_master = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] read_out_I = '0;
  logic [3:0] read_out_Q = '0;
  logic [3:0] out_data;
  logic [0:0] out_ch;
  logic       out_q;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] frame_cnt;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] got_d [8];
  logic [0:0] got_c [8];
  logic       got_q [8];
  logic       got_l [8];
  int         got_n;
  int         stall_err;
  bit         timed_out;
  logic [3:0] exp_d [4];

  readout_decimator #(.N_CH(2), .DEC_LOG2(2)) dut (
    .clk_master (clk_master),
    .rst        (rst),
    .en         (en),
    .sample_en  (sample_en),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_q      (out_q),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun)
  );

  always #5 clk_master = ~clk_master;

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  task automatic strobes(input int n, input logic [3:0] vi, input logic [3:0] vq);
    read_out_I = vi;
    read_out_Q = vq;
    sample_en  = 1'b1;
    repeat (n) tick();
    sample_en  = 1'b0;
  endtask

  // Records accepted words; optionally toggles out_ready each cycle and
  // counts any change of the presented word while stalled.
  task automatic collect(input bit toggle);
    logic [7:0] held;
    bit         holding;
    bit         done;
    got_n = 0; stall_err = 0; timed_out = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (toggle && cyc > 0) out_ready = ~out_ready;
      holding = 1'b0;
      if (out_valid && out_ready) begin
        if (got_n < 8) begin
          got_d[got_n] = out_data; got_c[got_n] = out_ch;
          got_q[got_n] = out_q;    got_l[got_n] = out_last;
        end
        got_n++;
        if (out_last) done = 1'b1;
      end else if (out_valid) begin
        holding = 1'b1;
        held = {out_data, out_ch, out_q, out_last, 1'b1};
      end
      tick();
      if (holding && ({out_data, out_ch, out_q, out_last, out_valid} !== held)) stall_err++;
    end
    if (done) timed_out = 1'b0;
  endtask

  task automatic check_frame(input string name);
    total_cnt++;
    if (timed_out || got_n !== 4) $display("FAIL %s word_count got=%0d timeout=%0d want=4", name, got_n, timed_out);
    else pass_cnt++;
    for (int k = 0; k < 4 && k < got_n; k++) begin
      total_cnt++;
      if (got_d[k] !== exp_d[k] || got_c[k] !== 1'(k >> 1) || got_q[k] !== 1'(k & 1) || got_l[k] !== (k == 3))
        $display("FAIL %s word%0d got d=%0d ch=%0d q=%0d last=%0d want d=%0d ch=%0d q=%0d last=%0d",
                 name, k, got_d[k], got_c[k], got_q[k], got_l[k], exp_d[k], k >> 1, k & 1, k == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s valid_drop got=%0b want=0", name, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({out_valid, out_data, out_ch, out_q, out_last, frame_cnt, overrun} !== 17'd0)
      $display("FAIL reset_outputs got v=%0b d=%0d fc=%0d ov=%0b want all 0", out_valid, out_data, frame_cnt, overrun);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_scale();
    out_ready = 1'b1;
    strobes(4, 4'hF, 4'h0);
    total_cnt++;
    if (out_valid !== 1'b1 || frame_cnt !== 8'd1)
      $display("FAIL full_latency got v=%0b fc=%0d want v=1 fc=1", out_valid, frame_cnt);
    else pass_cnt++;
    exp_d = '{4'd8, 4'd0, 4'd8, 4'd0};
    collect(1'b0);
    check_frame("full_scale");
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    strobes(4, 4'b0110, 4'b1101);
    exp_d = '{4'd4, 4'd4, 4'd4, 4'd8};
    collect(1'b1);
    check_frame("back_pressure");
    total_cnt++;
    if (stall_err !== 0 || frame_cnt !== 8'd2)
      $display("FAIL bp_stable got stall_err=%0d fc=%0d want 0 fc=2", stall_err, frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    strobes(4, 4'b0001, 4'b1000);
    strobes(4, 4'hF, 4'hF);
    total_cnt++;
    if (overrun !== 1'b1 || frame_cnt !== 8'd3)
      $display("FAIL overrun_flag got ov=%0b fc=%0d want ov=1 fc=3", overrun, frame_cnt);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'd4 || out_ch !== 1'b0 || out_q !== 1'b0)
      $display("FAIL overrun_hold got v=%0b d=%0d ch=%0d q=%0b want v=1 d=4 ch=0 q=0", out_valid, out_data, out_ch, out_q);
    else pass_cnt++;
    out_ready = 1'b1;
    exp_d = '{4'd4, 4'd0, 4'd0, 4'd4};
    collect(1'b0);
    check_frame("overrun_release");
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    strobes(4, 4'hF, 4'hF);
    strobes(1, 4'hF, 4'hF);
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({out_valid, out_data, out_ch, out_q, out_last, frame_cnt, overrun} !== 17'd0)
      $display("FAIL mid_reset got v=%0b d=%0d fc=%0d ov=%0b want all 0", out_valid, out_data, frame_cnt, overrun);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    strobes(3, 4'hF, 4'h0);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_wcnt got v=%0b after 3 strobes want 0", out_valid);
    else pass_cnt++;
    strobes(1, 4'hF, 4'h0);
    total_cnt++;
    if (out_valid !== 1'b1 || frame_cnt !== 8'd1)
      $display("FAIL reset_window got v=%0b fc=%0d want v=1 fc=1", out_valid, frame_cnt);
    else pass_cnt++;
    exp_d = '{4'd8, 4'd0, 4'd8, 4'd0};
    collect(1'b0);
    check_frame("after_reset");
  endtask

  task automatic test_en_gating();
    out_ready = 1'b1;
    strobes(1, 4'hF, 4'h0);
    en = 1'b0;
    strobes(3, 4'hF, 4'hF);
    en = 1'b1;
    strobes(2, 4'h0, 4'b0011);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL en_timing got v=%0b after 3 enabled strobes want 0", out_valid);
    else pass_cnt++;
    strobes(1, 4'h0, 4'b0011);
    total_cnt++;
    if (out_valid !== 1'b1 || frame_cnt !== 8'd2)
      $display("FAIL en_frame got v=%0b fc=%0d want v=1 fc=2", out_valid, frame_cnt);
    else pass_cnt++;
    exp_d = '{4'd2, 4'd6, 4'd2, 4'd0};
    collect(1'b0);
    check_frame("en_gating");
  endtask

  task automatic test_coincide();
    out_ready = 1'b0;
    read_out_I = 4'hF;
    read_out_Q = 4'h0;
    sample_en  = 1'b1;
    repeat (4) tick();
    out_ready = 1'b1;
    repeat (4) tick();
    sample_en = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || frame_cnt !== 8'd3)
      $display("FAIL coincide got v=%0b ov=%0b fc=%0d want v=0 ov=1 fc=3", out_valid, overrun, frame_cnt);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL coincide_drop got v=%0b want 0", out_valid);
    else pass_cnt++;
    strobes(4, 4'h0, 4'h0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'd0 || frame_cnt !== 8'd4)
      $display("FAIL coincide_next got v=%0b d=%0d fc=%0d want v=1 d=0 fc=4", out_valid, out_data, frame_cnt);
    else pass_cnt++;
    collect(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_back_pressure();
    test_overrun();
    test_mid_reset();
    test_en_gating();
    test_coincide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
